// File: rtl/nibble_serial_rx.sv
// Serial deframer: start bit, DATA_W data bits LSB first, even parity, stop bit, all sampled on
// bit_en. Each completed frame is offered as a word plus error flag over a valid/ready handshake.
module nibble_serial_rx #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              rx,
   input  logic              out_ready,
   output logic [DATA_W-1:0] in_data,
   output logic              input_err,
   output logic              in_valid,
   output logic              overrun,
   output logic              busy
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_next;
   logic              perr_q;
   logic              frame_done;
   logic              out_free;

   // New bits enter at the MSB so the first (LSB) bit ends up in bit 0 after DATA_W shifts.
   generate
      if (DATA_W == 1) begin : g_shift_one
         assign shift_next = rx;
      end else begin : g_shift_many
         assign shift_next = {rx, shift_q[DATA_W-1:1]};
      end
   endgenerate

   assign frame_done = bit_en && (state == S_STOP);
   assign out_free   = !in_valid || out_ready;
   assign busy       = (state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
      end else if (bit_en) begin
         case (state)
            S_IDLE: begin
               if (!rx) begin
                  state <= S_DATA;
                  cnt   <= '0;
               end
            end
            S_DATA: begin
               shift_q <= shift_next;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) state <= S_PARITY;
            end
            S_PARITY: begin
               perr_q <= (^shift_q) ^ rx;
               state  <= S_STOP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_data   <= '0;
         input_err <= 1'b0;
         in_valid  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (in_valid && out_ready) in_valid <= 1'b0;
         // NOTE: a frame completing on the consume edge must win, so its update comes last.
         if (frame_done) begin
            if (out_free) begin
               in_data   <= shift_q;
               input_err <= perr_q | !rx;
               in_valid  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_rx.sv
// Bench for nibble_serial_rx: directed frames from the test plan, then randomized frames with
// random bit-strobe gaps and consumer stalls, checked against a frame-level expectation model.
module tb_nibble_serial_rx;

   localparam int DATA_W = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              bit_en;
   logic              rx;
   logic              out_ready;
   logic [DATA_W-1:0] in_data;
   logic              input_err;
   logic              in_valid;
   logic              overrun;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic              exp_valid;
   logic [DATA_W-1:0] exp_data;
   logic              exp_err;
   logic              exp_ovr;
   logic [DATA_W-1:0] rnd_d;
   logic              rnd_bp;
   logic              rnd_bs;
   logic              rnd_r;

   always #5 clk = ~clk;

   nibble_serial_rx #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_en),
      .rx        (rx),
      .out_ready (out_ready),
      .in_data   (in_data),
      .input_err (input_err),
      .in_valid  (in_valid),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                            input logic e, input logic o);
      check({tag, ".valid"}, 16'(in_valid), 16'(v));
      check({tag, ".data"}, 16'(in_data), 16'(d));
      check({tag, ".err"}, 16'(input_err), 16'(e));
      check({tag, ".overrun"}, 16'(overrun), 16'(o));
   endtask

   task automatic check_zero(input string tag);
      check_out(tag, 1'b0, '0, 1'b0, 1'b0);
      check({tag, ".busy"}, 16'(busy), 16'd0);
   endtask

   // One strobed sample, then 0..2 unstrobed cycles with rx scrambled (must be ignored).
   task automatic send_bit(input logic b);
      rx     = b;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      repeat ($urandom_range(2, 0)) begin
         rx = 1'($urandom);
         tick();
      end
   endtask

   // Sends a whole frame; returns just after the stop-sample edge with out_ready = rdy_stop there.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic bad_par,
                             input logic bad_stop, input logic rdy_stop);
      int ones;
      ones = $countones(d);
      send_bit(1'b0);
      for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
      send_bit(ones[0] ^ bad_par);
      out_ready = rdy_stop;
      rx        = !bad_stop;
      bit_en    = 1'b1;
      tick();
      bit_en    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst_n     = 1'b0;
      bit_en    = 1'b0;
      rx        = 1'b1;
      out_ready = 1'b0;
      repeat (2) tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // Clean frame, immediately consumed.
      out_ready = 1'b1;
      send_frame(4'hB, 1'b0, 1'b0, 1'b1);
      check_out("t1", 1'b1, 4'hB, 1'b0, 1'b0);
      tick();
      check("t1.consumed", 16'(in_valid), 16'd0);

      send_frame(4'hB, 1'b1, 1'b0, 1'b1);
      check_out("t2_parity", 1'b1, 4'hB, 1'b1, 1'b0);
      tick();

      // Framing error, then a new frame straight after.
      send_frame(4'h4, 1'b0, 1'b1, 1'b1);
      check_out("t3_frame", 1'b1, 4'h4, 1'b1, 1'b0);
      check("t3.busy", 16'(busy), 16'd0);
      tick();
      send_frame(4'h1, 1'b0, 1'b0, 1'b1);
      check_out("t3_next", 1'b1, 4'h1, 1'b0, 1'b0);
      tick();

      // Stalled consumer: second frame dropped.
      out_ready = 1'b0;
      send_frame(4'h3, 1'b0, 1'b0, 1'b0);
      check_out("t4_first", 1'b1, 4'h3, 1'b0, 1'b0);
      tick();
      send_frame(4'h5, 1'b0, 1'b0, 1'b0);
      check_out("t4_drop", 1'b1, 4'h3, 1'b0, 1'b1);
      tick();
      check("t4.ovr_pulse", 16'(overrun), 16'd0);
      out_ready = 1'b1;
      tick();
      check("t4.released", 16'(in_valid), 16'd0);
      check("t4.data_held", 16'(in_data), 16'h3);

      // Ready arrives on the very stop edge of the second frame.
      out_ready = 1'b0;
      send_frame(4'h3, 1'b0, 1'b0, 1'b0);
      tick();
      send_frame(4'h5, 1'b0, 1'b0, 1'b1);
      check_out("t5_edge", 1'b1, 4'h5, 1'b0, 1'b0);
      tick();
      check("t5.consumed", 16'(in_valid), 16'd0);

      // Reset mid-frame, then a fresh frame.
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      check("t6.busy", 16'(busy), 16'd1);
      #2 rst_n = 1'b0;
      #1 check_zero("t6_reset");
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(4'hA, 1'b0, 1'b0, 1'b1);
      check_out("t6_after", 1'b1, 4'hA, 1'b0, 1'b0);
      tick();

      // Random frames against the frame-level model.
      exp_valid = 1'b0;
      exp_data  = 4'hA;
      exp_err   = 1'b0;
      for (int n = 0; n < 40; n++) begin
         rnd_d     = DATA_W'($urandom);
         rnd_bp    = ($urandom_range(3, 0) == 0);
         rnd_bs    = ($urandom_range(3, 0) == 0);
         rnd_r     = 1'($urandom_range(1, 0));
         out_ready = rnd_r;
         if (rnd_r) exp_valid = 1'b0;
         send_frame(rnd_d, rnd_bp, rnd_bs, rnd_r);
         exp_ovr = exp_valid && !rnd_r;
         if (!exp_ovr) begin
            exp_valid = 1'b1;
            exp_data  = rnd_d;
            exp_err   = rnd_bp | rnd_bs;
         end
         check_out("rnd", exp_valid, exp_data, exp_err, exp_ovr);
         tick();
         if (rnd_r) exp_valid = 1'b0;
         check("rnd.after", 16'(in_valid), 16'(exp_valid));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nibble_serial_rx.md
Name: nibble_serial_rx

Overview:
Serial front-end stage that feeds the 4-bit input consumer. It deframes a one-wire serial stream into a DATA_W-bit word and an input_err flag, then presents them with a valid/ready handshake. Bits are sampled on an externally supplied bit-rate strobe. Frame format: start bit (0), DATA_W data bits LSB first, even-parity bit, stop bit (1).

Parameters:
DATA_W, 4, width of the data word per frame (1..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
bit_en  input  1  one-cycle strobe, once per bit period; rx is sampled only when high
rx  input  1  serial line, idles high
out_ready  input  1  consumer accepts the word when high together with in_valid
in_data  output  DATA_W  received word, registered
input_err  output  1  error flag for the word on in_data (parity or framing), registered
in_valid  output  1  in_data/input_err hold a word that has not been consumed
overrun  output  1  one-cycle pulse when a completed frame is dropped
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_data=0, input_err=0, in_valid=0, overrun=0, busy=0; shift register and bit counter cleared. Reset mid-frame discards the partial frame, with no output update.
- Without bit_en the state machine holds state; rx is ignored.
- States:
  - IDLE: on bit_en & rx==0 go to DATA, cnt=0. On bit_en & rx==1 stay in IDLE.
  - DATA: on bit_en, shift rx into the shift register MSB (shift right, giving LSB-first assembly) and increment cnt. After the DATA_W-th sample go to PARITY.
  - PARITY: on bit_en, perr = (XOR of data bits) XOR rx. Even parity means perr=0 when the total count of ones, parity bit included, is even. Go to STOP.
  - STOP: on bit_en, ferr = (rx==0). Go to IDLE and complete the frame in the same cycle.
- No glitch filtering of the start bit: a single low sample in IDLE starts a frame.
- Frame completion at the STOP-sample edge:
  - If the output is free (in_valid==0, or in_valid & out_ready in that same cycle): load in_data=shift register, input_err=perr|ferr, in_valid=1.
  - Otherwise (in_valid & !out_ready): drop the new frame, leave the outputs unchanged, and pulse overrun=1 for exactly one cycle.
- Latency: in_valid rises on the clock edge where the stop bit is sampled, and is visible the following cycle.
- Handshake: in_valid & out_ready on an edge with no frame completing → in_valid=0 next cycle. in_data and input_err stay unchanged after consumption until the next load. While in_valid=1 and out_ready=0, the outputs are held stable.
- Framing error: the word is still delivered with input_err=1. The next frame may start immediately. A low rx at the next IDLE sample is treated as a new start bit; no break detection.
- overrun is 0 in every cycle other than the drop cycle.
- Back-to-back frames: a start bit may be sampled on the first bit_en after STOP. No idle bit period is required.

Test Plan:
- Reset, then with out_ready=1 send rx bits 0,1,1,0,1,1,1 on bit_en → in_data=4'hB, input_err=0, in_valid=1 for exactly 1 cycle, overrun=0.
- Send 0,1,1,0,1,0,1 (parity wrong) → in_data=4'hB, input_err=1, in_valid=1.
- Send 0,0,0,1,0,1,0 (stop low) → in_data=4'h4, input_err=1. Then immediately send bits 1,0,0,0,1,1 → in_data=4'h1, input_err=0 (the low stop sample does not start a frame; a new start is needed, so the 6-bit tail only completes after its own start bit).
- Hold out_ready=0 and send 4'h3 then 4'h5 back-to-back → in_data stays 4'h3, in_valid=1, overrun pulses 1 cycle at the second stop. Raise out_ready → in_valid=0 next cycle.
- Raise out_ready exactly at the second frame's stop-sample edge → in_data=4'h5, in_valid stays 1, overrun=0.
- Assert rst_n=0 after the second data bit, release, send 4'hA → only 4'hA delivered, input_err=0. All outputs are 0 during reset.
